// File: rtl/stopwatch_pkg.sv
// Shared definitions for the countdown timer.
// Holds the FSM state codes, the field limits and the clamped tick divisor helper.
// Build option DEBOUNCE_EN (see btn_cond) uses DB_MS.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SET   = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_ALARM = 2'd3;

  localparam logic [6:0] CS_MAX = 7'd99;
  localparam logic [6:0] S_MAX  = 7'd59;
  localparam logic [6:0] M_MAX  = 7'd99;

  localparam int unsigned DB_MS = 10;

  // (clk_hz / tick_hz) >> quick, never below 1 so the divider always wraps.
  function automatic logic [31:0] tick_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz,
                                           input logic [3:0]  quick);
    logic [31:0] d;
    d = 32'(clk_hz / tick_hz) >> quick;
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// User-facing signal bundle of the countdown timer.
//   quick      : tick divisor shift (speed-up)
//   start_stop, btn_min, btn_sec, clr : raw buttons, active-high
//   value_m/s/cs : registered minutes / seconds / centiseconds
//   running, alarm : registered state flags
// master drives the buttons (board / bench), slave is the timer.
interface countdown_timer_if;
  logic [3:0] quick;
  logic       start_stop;
  logic       btn_min;
  logic       btn_sec;
  logic       clr;
  logic [6:0] value_m;
  logic [6:0] value_s;
  logic [6:0] value_cs;
  logic       running;
  logic       alarm;

  modport master (output quick, start_stop, btn_min, btn_sec, clr,
                  input  value_m, value_s, value_cs, running, alarm);
  modport slave  (input  quick, start_stop, btn_min, btn_sec, clr,
                  output value_m, value_s, value_cs, running, alarm);
endinterface

// File: rtl/btn_cond.sv
// Button conditioner: 2-FF synchronizer, optional debouncer, rising-edge pulse.
//   clk, rst  : clock, async active-low reset
//   btn_i     : raw button level
//   pulse_o   : one-cycle pulse per press (combinational from registered state)
// With DEBOUNCE_EN defined the synchronized level must differ from the
// conditioned level for DB_CYCLES consecutive cycles before it is accepted.
module btn_cond
`ifdef DEBOUNCE_EN
#(
  parameter int unsigned DB_CYCLES = 10
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  logic s1_q, s2_q, prev_q, lvl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] db_cnt_q;
  logic          db_lvl_q;

  // Any bounce back to the accepted level restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else if (s2_q == db_lvl_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
      db_lvl_q <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end
  assign lvl = db_lvl_q;
`else
  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= lvl;
  end

  assign pulse_o = lvl & ~prev_q;
endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: preset mm:ss with buttons, count down in centiseconds,
// pause/resume, alarm at 00:00.00 with auto-return to SET.
//   clk, rst : clock, async active-low reset
//   bus      : countdown_timer_if.slave (buttons, quick, values, flags)
// Build option DEBOUNCE_EN adds a 10 ms debouncer to every button.
module countdown_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned ALARM_TICKS = 300
) (
  input  logic             clk,
  input  logic             rst,
  countdown_timer_if.slave bus
);
  localparam logic [31:0] BASE_DIV   = 32'(CLK_HZ / TICK_HZ);
  localparam logic [31:0] ALARM_LAST = 32'(ALARM_TICKS - 1);

  logic [3:0] raw, pls;
  logic       ss_p, min_p, sec_p, clr_p;

  assign raw = {bus.clr, bus.btn_sec, bus.btn_min, bus.start_stop};
  assign {clr_p, sec_p, min_p, ss_p} = pls;

`ifdef DEBOUNCE_EN
  btn_cond #(.DB_CYCLES(CLK_HZ / 1000 * DB_MS)) u_btn [3:0] (
    .clk(clk), .rst(rst), .btn_i(raw), .pulse_o(pls));
`else
  btn_cond u_btn [3:0] (.clk(clk), .rst(rst), .btn_i(raw), .pulse_o(pls));
`endif

  state_t      state_q, state_d;
  logic [6:0]  m_q, m_d, s_q, s_d, cs_q, cs_d, pm_q, pm_d, ps_q, ps_d;
  logic [31:0] cnt_q, cnt_d, div_q, div_d, adiv_q, adiv_d, acnt_q, acnt_d;
  logic        running_q, alarm_q, tick, atick, stay_alarm;

  // div_q is only reloaded at a wrap while counting, so quick changes
  // mid-period take effect on the following period.
  assign tick       = (state_q == ST_RUN) && (cnt_q >= div_q - 32'd1);
  // Alarm duration uses the undivided rate, independent of quick.
  assign atick      = (state_q == ST_ALARM) && (adiv_q >= BASE_DIV - 32'd1);
  assign stay_alarm = (state_q == ST_ALARM) && (state_d == ST_ALARM);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cs_d    = cs_q;
    pm_d    = pm_q;
    ps_d    = ps_q;
    case (state_q)
      ST_SET: begin
        if (min_p) m_d = (m_q == M_MAX) ? '0 : m_q + 7'd1;
        if (sec_p) s_d = (s_q == S_MAX) ? '0 : s_q + 7'd1;
        cs_d = '0;
        pm_d = m_d;
        ps_d = s_d;
        if (ss_p && (m_q != '0 || s_q != '0)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // start_stop wins over a coincident tick: no decrement.
        if (ss_p) state_d = ST_PAUSE;
        else if (tick) begin
          if (m_q == '0 && s_q == '0 && cs_q == 7'd1) begin
            cs_d    = '0;
            state_d = ST_ALARM;
          end else if (cs_q != '0) begin
            cs_d = cs_q - 7'd1;
          end else begin
            cs_d = CS_MAX;
            if (s_q != '0) s_d = s_q - 7'd1;
            else begin
              s_d = S_MAX;
              m_d = m_q - 7'd1;
            end
          end
        end
      end
      ST_PAUSE: if (ss_p) state_d = ST_RUN;
      default: begin
        if (ss_p || (atick && acnt_q == ALARM_LAST)) begin
          state_d = ST_SET;
          m_d     = pm_q;
          s_d     = ps_q;
          cs_d    = '0;
        end
      end
    endcase
    if (clr_p) begin
      state_d = ST_SET;
      m_d     = '0;
      s_d     = '0;
      cs_d    = '0;
      pm_d    = '0;
      ps_d    = '0;
    end
  end

  always_comb begin
    div_d = div_q;
    if ((state_q != ST_RUN && state_q != ST_PAUSE) || tick)
      div_d = tick_div(CLK_HZ, TICK_HZ, bus.quick);
    // Divider advances only while in RUN, holds across PAUSE, zero elsewhere.
    cnt_d = '0;
    if (state_d == ST_RUN || state_d == ST_PAUSE)
      cnt_d = (state_q == ST_RUN) ? (tick ? 32'd0 : cnt_q + 32'd1) : cnt_q;
    adiv_d = stay_alarm ? (atick ? 32'd0 : adiv_q + 32'd1) : 32'd0;
    acnt_d = stay_alarm ? (atick ? acnt_q + 32'd1 : acnt_q) : 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SET;
      m_q       <= '0;
      s_q       <= '0;
      cs_q      <= '0;
      pm_q      <= '0;
      ps_q      <= '0;
      cnt_q     <= '0;
      div_q     <= 32'd1;
      adiv_q    <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      s_q       <= s_d;
      cs_q      <= cs_d;
      pm_q      <= pm_d;
      ps_q      <= ps_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      adiv_q    <= adiv_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
    end
  end

  assign bus.value_m  = m_q;
  assign bus.value_s  = s_q;
  assign bus.value_cs = cs_q;
  assign bus.running  = running_q;
  assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_HZ=1000, TICK_HZ=100, ALARM_TICKS=5).
// A reference model tracks the remaining time as one integer of centiseconds and
// pushes the expected outputs every cycle; a monitor pops and compares on negedge.
module tb_countdown_timer;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int AT = 5;
  localparam int BASE = CLK_HZ / TICK_HZ;
  localparam logic [3:0] SS = 4'b0001, MN = 4'b0010, SC = 4'b0100, CL = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_if bus();
  countdown_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ALARM_TICKS(AT)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct { int m; int s; int cs; bit run; bit alm; } exp_t;
  typedef enum int { M_SET, M_RUN, M_PAUSE, M_ALARM } mmode_t;

  exp_t   sbq[$];
  int     n_chk = 0, n_fail = 0;
  mmode_t md = M_SET;
  int     mset, sset, pm, ps, rem, phase, div, aphase, acnt;
  bit [3:0] r1, r2, r3;

  function automatic int fdiv(int q);
    int d;
    d = BASE >> q;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    if (md == M_SET) begin e.m = mset; e.s = sset; e.cs = 0; end
    else begin e.m = rem / 6000; e.s = (rem / 100) % 60; e.cs = rem % 100; end
    e.run = (md == M_RUN);
    e.alm = (md == M_ALARM);
    return e;
  endfunction

  // Reference model: button pulse acts 3 edges after the raw rising edge.
  always @(posedge clk or negedge rst) begin : ref_model
    bit [3:0] p;
    mmode_t   old;
    bit       tk, done, nz;
    if (!rst) begin
      md = M_SET; mset = 0; sset = 0; pm = 0; ps = 0; rem = 0;
      phase = 0; div = 1; aphase = 0; acnt = 0; r1 = '0; r2 = '0; r3 = '0;
      sbq.delete();
      if (clk) sbq.push_back(cur_exp());
    end else begin
      p  = r2 & ~r3;
      r3 = r2; r2 = r1;
      r1 = {bus.clr, bus.btn_sec, bus.btn_min, bus.start_stop};
      old = md; tk = 0; done = 0;
      if (old == M_RUN) begin
        phase++;
        if (phase >= div) begin tk = 1; phase = 0; div = fdiv(int'(bus.quick)); end
      end else if (old != M_PAUSE) begin
        phase = 0; div = fdiv(int'(bus.quick));
      end
      if (old == M_ALARM) begin
        aphase++;
        if (aphase == BASE) begin aphase = 0; acnt++; done = (acnt == AT); end
      end else begin
        aphase = 0; acnt = 0;
      end
      if (p[3]) begin
        md = M_SET; mset = 0; sset = 0; pm = 0; ps = 0; rem = 0;
      end else begin
        case (old)
          M_SET: begin
            nz = (mset != 0) || (sset != 0);
            if (p[1]) mset = (mset + 1) % 100;
            if (p[2]) sset = (sset + 1) % 60;
            pm = mset; ps = sset;
            if (p[0] && nz) begin md = M_RUN; rem = mset * 6000 + sset * 100; end
          end
          M_RUN: begin
            if (p[0]) md = M_PAUSE;
            else if (tk) begin rem--; if (rem == 0) md = M_ALARM; end
          end
          M_PAUSE: if (p[0]) md = M_RUN;
          default: if (p[0] || done) begin md = M_SET; mset = pm; sset = ps; end
        endcase
      end
      sbq.push_back(cur_exp());
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [22:0] a, x;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {bus.value_m, bus.value_s, bus.value_cs, bus.running, bus.alarm};
      x = {7'(e.m), 7'(e.s), 7'(e.cs), e.run, e.alm};
      n_chk++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL sb_out @%0t: got %0d:%0d.%0d run=%0b alm=%0b expected %0d:%0d.%0d run=%0b alm=%0b",
                 $time, bus.value_m, bus.value_s, bus.value_cs, bus.running, bus.alarm,
                 e.m, e.s, e.cs, e.run, e.alm);
      end
    end
  end

  task automatic spot(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(logic [3:0] msk);
    {bus.clr, bus.btn_sec, bus.btn_min, bus.start_stop} = msk;
  endtask

  task automatic press(logic [3:0] msk, int hold = 2, int gap = 2);
    @(negedge clk);
    drive(msk);
    idle(hold);
    drive(4'b0);
    idle(gap);
  endtask

  task automatic wait_rem(int target, int bound);
    int k = 0;
    while (!(md == M_RUN && rem == target) && k < bound) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= bound) begin
      n_fail++;
      $display("FAIL wait_rem: remaining %0d not reached within %0d cycles (now %0d)", target, bound, rem);
    end
  endtask

  task automatic wait_phase(int target, int bound);
    int k = 0;
    while (!(md == M_RUN && phase == target) && k < bound) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= bound) begin
      n_fail++;
      $display("FAIL wait_phase: phase %0d not reached within %0d cycles", target, bound);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int snap;
    bus.quick = 4'd0;
    drive(4'b0);
    idle(3);
    spot("reset_running", 32'(bus.running), 32'd0);
    spot("reset_alarm", 32'(bus.alarm), 32'd0);
    rst = 1'b1;
    idle(2);

    // Preset entry and wrap-around.
    repeat (3) press(MN);
    repeat (61) press(SC);
    idle(4);
    spot("set_m3", 32'(bus.value_m), 32'd3);
    spot("set_s1", 32'(bus.value_s), 32'd1);
    repeat (100) press(MN);
    idle(4);
    spot("min_wrap", 32'(bus.value_m), 32'd3);

    // Start at 00:00 is ignored.
    press(CL); idle(4);
    press(SS); idle(6);
    spot("start_zero_ignored", 32'(bus.running), 32'd0);

    // 01:00.00 -> first tick gives 00:59.99.
    press(MN); idle(4);
    press(SS); idle(11);
    spot("borrow_m", 32'(bus.value_m), 32'd0);
    spot("borrow_s", 32'(bus.value_s), 32'd59);
    spot("borrow_cs", 32'(bus.value_cs), 32'd99);
    press(CL); idle(4);

    // 00:01 to alarm, then auto-return with preset reloaded.
    press(SC); idle(4);
    press(SS); idle(1006);
    spot("alarm_on", 32'(bus.alarm), 32'd1);
    spot("alarm_cs", 32'(bus.value_cs), 32'd0);
    idle(60);
    spot("alarm_off", 32'(bus.alarm), 32'd0);
    spot("reload_s", 32'(bus.value_s), 32'd1);
    spot("reload_m", 32'(bus.value_m), 32'd0);

    // Pause at 00:00.50, hold, resume.
    press(SS);
    wait_rem(50, 1000);
    press(SS); idle(200);
    spot("pause_frozen", 32'(bus.value_cs), 32'd50);
    spot("pause_running", 32'(bus.running), 32'd0);
    press(SS); idle(30);

    // start_stop pulse coincident with a tick.
    wait_phase(BASE - 3, 50);
    snap = rem;
    drive(SS); idle(2); drive(4'b0); idle(2);
    spot("coincident_pause", 32'(bus.running), 32'd0);
    spot("coincident_nodec", 32'(bus.value_cs), 32'(snap % 100));

    // clr beats start_stop in RUN.
    press(SS); idle(20);
    press(SS | CL); idle(5);
    spot("clr_ss_m", 32'(bus.value_m), 32'd0);
    spot("clr_ss_s", 32'(bus.value_s), 32'd0);
    spot("clr_ss_run", 32'(bus.running), 32'd0);

    // quick speed-up.
    repeat (5) press(SC);
    bus.quick = 4'd2;
    press(SS); idle(40);
    bus.quick = 4'd15; idle(40);
    bus.quick = 4'd0;
    press(CL); idle(4);

    // Asynchronous reset in the middle of a run.
    repeat (4) press(SC);
    press(SS);
    wait_rem(347, 1000);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    spot("async_rst_running", 32'(bus.running), 32'd0);
    spot("async_rst_s", 32'(bus.value_s), 32'd0);
    spot("async_rst_cs", 32'(bus.value_cs), 32'd0);
    idle(3);
    rst = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      int r, qs;
      r = $urandom_range(0, 99);
      if (r < 4) press(CL, $urandom_range(1, 4), $urandom_range(1, 3));
      else if (r < 12) begin
        qs = $urandom_range(0, 5);
        bus.quick = (qs == 5) ? 4'd15 : 4'(qs);
        idle(1);
      end
      else if (r < 40) press(4'(4'($urandom_range(1, 3)) << 1), $urandom_range(1, 4), $urandom_range(1, 3));
      else if (r < 62) press(SS, $urandom_range(1, 4), $urandom_range(1, 3));
      else if (r < 66) press(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 3));
      else idle($urandom_range(1, 40));
    end
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
